// File: rtl/scope_pkg.sv
// scope_pkg: shared types for the capture controller and its trigger detector
// Contents: capture-state enum, trigger-source enum, packed sample layout of wr_data
package scope_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_TRIG,
        ST_POST
    } cap_state_t;
    typedef enum logic [1:0] {
        TRIG_ANALOG0,
        TRIG_ANALOG1,
        TRIG_DIGITAL,
        TRIG_FORCE
    } trig_src_t;
    typedef struct packed {
        logic [7:0]  digital;
        logic [11:0] analog1;
        logic [11:0] analog0;
    } sample_t;
endpackage

// File: rtl/trigger_detector.sv
// trigger_detector: edge/level trigger compare against the previously accepted sample
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   i_clear      - drop the previous-sample valid flag (new capture armed)
//   i_update     - current sample accepted; becomes the previous sample
//   i_cur        - current sample
//   i_src/i_bit/i_level/i_edge - latched trigger configuration
//   o_hit        - current sample satisfies the trigger condition
module trigger_detector
    import scope_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_update,
    input  sample_t     i_cur,
    input  trig_src_t   i_src,
    input  logic [2:0]  i_bit,
    input  logic [11:0] i_level,
    input  logic        i_edge,
    output logic        o_hit
);
    sample_t     r_prev;
    logic        r_prev_valid;
    logic [11:0] w_prev_an;
    logic [11:0] w_cur_an;
    logic        w_prev_bit;
    logic        w_cur_bit;
    logic        w_an_rise;
    logic        w_an_fall;
    logic        w_dig_rise;
    logic        w_dig_fall;
    logic        w_edge_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_clear) begin
            r_prev_valid <= 1'b0;
        end else if (i_update) begin
            r_prev       <= i_cur;
            r_prev_valid <= 1'b1;
        end
    end

    assign w_prev_an  = (i_src == TRIG_ANALOG1) ? r_prev.analog1 : r_prev.analog0;
    assign w_cur_an   = (i_src == TRIG_ANALOG1) ? i_cur.analog1 : i_cur.analog0;
    assign w_prev_bit = r_prev.digital[i_bit];
    assign w_cur_bit  = i_cur.digital[i_bit];
    assign w_an_rise  = (w_prev_an < i_level) && (w_cur_an >= i_level);
    assign w_an_fall  = (w_prev_an >= i_level) && (w_cur_an < i_level);
    assign w_dig_rise = !w_prev_bit && w_cur_bit;
    assign w_dig_fall = w_prev_bit && !w_cur_bit;
    assign w_edge_hit = (i_src == TRIG_DIGITAL) ? (i_edge ? w_dig_fall : w_dig_rise)
                                                : (i_edge ? w_an_fall : w_an_rise);
    // Force needs no history; edge modes need a real previous sample
    assign o_hit = (i_src == TRIG_FORCE) || (r_prev_valid && w_edge_hit);
endmodule

// File: rtl/capture_controller.sv
// capture_controller: pre/post-trigger circular capture into a 2**ADDR_W sample buffer
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   arm, abort           - one-cycle capture start / cancel requests
//   sample_valid         - strobe qualifying analog_in/digital_in
//   trig_src..pretrig    - capture configuration, latched on arm
//   wr_en/wr_addr/wr_data - buffer write port, one cycle after each accepted sample
//   busy, done           - capture in progress / one-cycle completion pulse
//   trig_addr/start_addr - trigger sample address and oldest valid sample address
module capture_controller
    import scope_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   sample_valid,
    input  logic [1:0][11:0]       analog_in,
    input  logic [7:0]             digital_in,
    input  logic [1:0]             trig_src,
    input  logic [2:0]             trig_bit,
    input  logic [11:0]            trig_level,
    input  logic                   trig_edge,
    input  logic [ADDR_W-1:0]      pretrig,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [31:0]            wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      trig_addr,
    output logic [ADDR_W-1:0]      start_addr
);
    cap_state_t        r_state;
    trig_src_t         r_src;
    logic [2:0]        r_bit;
    logic [11:0]       r_level;
    logic              r_edge;
    logic [ADDR_W-1:0] r_pretrig;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W-1:0] r_start_addr;
    logic              r_wr_en;
    logic              r_done;
    sample_t           r_wr_data;
    sample_t           w_sample;
    logic              w_active;
    logic              w_arm;
    logic              w_take;
    logic              w_hit;
    logic [ADDR_W-1:0] w_cnt_inc;
    logic [ADDR_W-1:0] w_post;

    assign w_sample  = {digital_in, analog_in[1], analog_in[0]};
    assign w_active  = (r_state != ST_IDLE);
    assign w_arm     = !w_active && arm;
    // abort wins over a coincident sample: nothing is written or evaluated
    assign w_take    = w_active && sample_valid && !abort;
    assign w_cnt_inc = r_cnt + 1'b1;
    // Samples remaining after the trigger: DEPTH-1-pretrig
    assign w_post    = {ADDR_W{1'b1}} - r_pretrig;

    trigger_detector u_trig (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_arm),
        .i_update (w_take),
        .i_cur    (w_sample),
        .i_src    (r_src),
        .i_bit    (r_bit),
        .i_level  (r_level),
        .i_edge   (r_edge),
        .o_hit    (w_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_src        <= TRIG_ANALOG0;
            r_bit        <= '0;
            r_level      <= '0;
            r_edge       <= 1'b0;
            r_pretrig    <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_done       <= 1'b0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
        end else begin
            r_wr_en <= w_take;
            r_done  <= 1'b0;
            if (w_take) begin
                r_wr_data <= w_sample;
                r_wr_addr <= r_ptr;
                r_ptr     <= r_ptr + 1'b1;
            end
            if (w_arm) begin
                r_src     <= trig_src_t'(trig_src);
                r_bit     <= trig_bit;
                r_level   <= trig_level;
                r_edge    <= trig_edge;
                r_pretrig <= pretrig;
                r_ptr     <= '0;
                r_wr_addr <= '0;
                r_cnt     <= '0;
                r_state   <= (pretrig == '0) ? ST_WAIT_TRIG : ST_PRE;
            end else if (w_active && abort) begin
                r_state <= ST_IDLE;
            end else if (w_take) begin
                if (r_state == ST_PRE) begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == r_pretrig)
                        r_state <= ST_WAIT_TRIG;
                end else if (r_state == ST_WAIT_TRIG && w_hit) begin
                    r_trig_addr  <= r_ptr;
                    r_start_addr <= r_ptr - r_pretrig;
                    r_cnt        <= w_post;
                    r_done       <= (w_post == '0);
                    r_state      <= (w_post == '0) ? ST_IDLE : ST_POST;
                end else if (r_state == ST_POST) begin
                    r_cnt   <= r_cnt - 1'b1;
                    r_done  <= (r_cnt == 1);
                    r_state <= (r_cnt == 1) ? ST_IDLE : ST_POST;
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = w_active;
    assign done       = r_done;
    assign trig_addr  = r_trig_addr;
    assign start_addr = r_start_addr;
endmodule
